pe_loader: RTL

Upstream feeder for the matrix-vector PE controller. Accepts a stream of IEEE-754 half-precision words and converts each to single precision. Writes them into the shared BRAM in the layout the PE controller reads: the N×N matrix row-major, then the N-element vector. When the last element is written, it pulses the controller's start, waits for its done, then reports completion.

---
 rtl/pe_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pe_loader.sv
// pe_loader: converts a half-precision input stream to single precision, writes it
// into the PE controller's BRAM (matrix row-major, then vector), kicks the PE and waits.
module pe_loader #(
    parameter int VECTOR_SIZE = 64,
    parameter int L_RAM_SIZE  = 6
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        run,
    output logic        busy,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        pe_start,
    input  logic        pe_done,
    output logic        done,
    output logic [31:0] BRAM_ADDR,
    output logic [31:0] BRAM_WRDATA,
    output logic [3:0]  BRAM_WE
);

    localparam int IDX_W       = 2 * L_RAM_SIZE + 1;
    localparam int TOTAL_WORDS = VECTOR_SIZE * VECTOR_SIZE + VECTOR_SIZE;
    localparam int PAD_W       = 32 - IDX_W - 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_KICK = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Subnormals flush to signed zero; Inf/NaN keep their payload; normals rebias 15 -> 127.
    function automatic logic [31:0] half_to_single(input logic [15:0] h);
        logic [31:0] f;
        if (h[14:10] == 5'd0) begin
            f = {h[15], 31'd0};
        end else if (h[14:10] == 5'h1F) begin
            f = {h[15], 8'hFF, h[9:0], 13'd0};
        end else begin
            f = {h[15], ({3'd0, h[14:10]} + 8'd112), h[9:0], 13'd0};
        end
        return f;
    endfunction

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              s_ready_q, s_ready_d;
    logic              pe_start_q, pe_start_d;
    logic              done_q, done_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wrdata_q, wrdata_d;
    logic [3:0]        we_q, we_d;
    logic              beat_acc_s;

    assign beat_acc_s = s_valid && (state_q == ST_LOAD);

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the terminal beat leaves LOAD so idx never wraps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_LOAD;
                else     state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (beat_acc_s && (idx_q == LAST_IDX)) state_d = ST_KICK;
                else                                   state_d = ST_LOAD;
            end
            ST_KICK: state_d = ST_WAIT;
            ST_WAIT: begin
                if (pe_done) state_d = ST_DONE;
                else         state_d = ST_WAIT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs are decoded from the state being entered so they line up with state_q.
    always_comb begin
        busy_d     = 1'b0;
        s_ready_d  = 1'b0;
        pe_start_d = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_LOAD: begin
                busy_d    = 1'b1;
                s_ready_d = 1'b1;
            end
            ST_KICK: begin
                busy_d     = 1'b1;
                pe_start_d = 1'b1;
            end
            ST_WAIT: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Element index and BRAM write port; address and data hold between writes with WE low.
    always_comb begin
        idx_d    = idx_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        we_d     = 4'h0;
        if ((state_q == ST_IDLE) && run) begin
            idx_d = IDX_ZERO;
        end else if (beat_acc_s) begin
            idx_d    = idx_q + IDX_ONE;
            addr_d   = {{PAD_W{1'b0}}, idx_q, 2'b00};
            wrdata_d = half_to_single(s_data);
            we_d     = 4'hF;
        end else begin
            idx_d = idx_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            idx_q      <= IDX_ZERO;
            busy_q     <= 1'b0;
            s_ready_q  <= 1'b0;
            pe_start_q <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= 32'd0;
            wrdata_q   <= 32'd0;
            we_q       <= 4'h0;
        end else begin
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            s_ready_q  <= s_ready_d;
            pe_start_q <= pe_start_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
            we_q       <= we_d;
        end
    end

    assign busy        = busy_q;
    assign s_ready     = s_ready_q;
    assign pe_start    = pe_start_q;
    assign done        = done_q;
    assign BRAM_ADDR   = addr_q;
    assign BRAM_WRDATA = wrdata_q;
    assign BRAM_WE     = we_q;

endmodule
